// File: rtl/ysyx_24110015_mem_arbiter.sv
// Two-master (IFU read-only, LSU read/write) to one-slave AXI4-Lite arbiter.
// Define MEM_ARBITER_RR_EN for round-robin tie-breaking; default is fixed LSU priority.
module ysyx_24110015_mem_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            rst,

    input  logic [AW-1:0]   ifu_araddr,
    input  logic            ifu_arvalid,
    output logic            ifu_arready,
    output logic [DW-1:0]   ifu_rdata,
    output logic [1:0]      ifu_rresp,
    output logic            ifu_rvalid,
    input  logic            ifu_rready,

    input  logic [AW-1:0]   lsu_araddr,
    input  logic            lsu_arvalid,
    output logic            lsu_arready,
    output logic [DW-1:0]   lsu_rdata,
    output logic [1:0]      lsu_rresp,
    output logic            lsu_rvalid,
    input  logic            lsu_rready,
    input  logic [AW-1:0]   lsu_awaddr,
    input  logic            lsu_awvalid,
    output logic            lsu_awready,
    input  logic [DW-1:0]   lsu_wdata,
    input  logic [DW/8-1:0] lsu_wstrb,
    input  logic            lsu_wvalid,
    output logic            lsu_wready,
    output logic [1:0]      lsu_bresp,
    output logic            lsu_bvalid,
    input  logic            lsu_bready,

    output logic [AW-1:0]   m_araddr,
    output logic            m_arvalid,
    input  logic            m_arready,
    input  logic [DW-1:0]   m_rdata,
    input  logic [1:0]      m_rresp,
    input  logic            m_rvalid,
    output logic            m_rready,
    output logic [AW-1:0]   m_awaddr,
    output logic            m_awvalid,
    input  logic            m_awready,
    output logic [DW-1:0]   m_wdata,
    output logic [DW/8-1:0] m_wstrb,
    output logic            m_wvalid,
    input  logic            m_wready,
    input  logic [1:0]      m_bresp,
    input  logic            m_bvalid,
    output logic            m_bready,

    output logic [1:0]      grant
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        IFU_R = 2'b01,
        LSU_R = 2'b10,
        LSU_W = 2'b11
    } state_t;

    state_t state;
    state_t lsu_cand;
    logic   lsu_req;
    logic   ifu_wins;
    logic   xfer_done;

    // Within the LSU a pending write always beats a pending read.
    always_comb begin
        lsu_req  = lsu_awvalid | lsu_arvalid;
        lsu_cand = lsu_awvalid ? LSU_W : LSU_R;
    end

    always_comb begin
        xfer_done = 1'b0;
        case (state)
            IFU_R:   xfer_done = m_rvalid & ifu_rready;
            LSU_R:   xfer_done = m_rvalid & lsu_rready;
            LSU_W:   xfer_done = m_bvalid & lsu_bready;
            default: xfer_done = 1'b0;
        endcase
    end

`ifdef MEM_ARBITER_RR_EN
    // 0 = IFU owned last, 1 = LSU owned last; the other side wins a tie.
    logic last_owner;

    always_ff @(posedge clk) begin
        if (!rst) begin
            last_owner <= 1'b0;
        end else if (xfer_done) begin
            last_owner <= (state != IFU_R);
        end
    end

    assign ifu_wins = ifu_arvalid & (~lsu_req | last_owner);
`else
    assign ifu_wins = ifu_arvalid & ~lsu_req;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (ifu_wins) begin
                        state <= IFU_R;
                    end else if (lsu_req) begin
                        state <= lsu_cand;
                    end
                end
                default: begin
                    if (xfer_done) begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

    assign grant = state;

    // Pure combinational routing off the registered owner; everything not owned is zero.
    always_comb begin
        ifu_arready = 1'b0;
        ifu_rdata   = '0;
        ifu_rresp   = '0;
        ifu_rvalid  = 1'b0;
        lsu_arready = 1'b0;
        lsu_rdata   = '0;
        lsu_rresp   = '0;
        lsu_rvalid  = 1'b0;
        lsu_awready = 1'b0;
        lsu_wready  = 1'b0;
        lsu_bresp   = '0;
        lsu_bvalid  = 1'b0;
        m_araddr    = '0;
        m_arvalid   = 1'b0;
        m_rready    = 1'b0;
        m_awaddr    = '0;
        m_awvalid   = 1'b0;
        m_wdata     = '0;
        m_wstrb     = '0;
        m_wvalid    = 1'b0;
        m_bready    = 1'b0;
        case (state)
            IFU_R: begin
                m_araddr    = ifu_araddr;
                m_arvalid   = ifu_arvalid;
                ifu_arready = m_arready;
                ifu_rdata   = m_rdata;
                ifu_rresp   = m_rresp;
                ifu_rvalid  = m_rvalid;
                m_rready    = ifu_rready;
            end
            LSU_R: begin
                m_araddr    = lsu_araddr;
                m_arvalid   = lsu_arvalid;
                lsu_arready = m_arready;
                lsu_rdata   = m_rdata;
                lsu_rresp   = m_rresp;
                lsu_rvalid  = m_rvalid;
                m_rready    = lsu_rready;
            end
            LSU_W: begin
                m_awaddr    = lsu_awaddr;
                m_awvalid   = lsu_awvalid;
                lsu_awready = m_awready;
                m_wdata     = lsu_wdata;
                m_wstrb     = lsu_wstrb;
                m_wvalid    = lsu_wvalid;
                lsu_wready  = m_wready;
                lsu_bresp   = m_bresp;
                lsu_bvalid  = m_bvalid;
                m_bready    = lsu_bready;
            end
            default: begin
            end
        endcase
    end

endmodule
